// File: rtl/axi_pkg.sv
// AXI encodings shared by the read master and read slave.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXSIZE_1 = 3'd0;
  localparam logic [2:0] AXSIZE_2 = 3'd1;
  localparam logic [2:0] AXSIZE_4 = 3'd2;
  localparam logic [2:0] AXSIZE_8 = 3'd3;

  // Keeps the low 8<<size bits of a right-justified 64-bit beat.
  function automatic logic [63:0] lane_mask(input logic [2:0] size);
    logic [63:0] mask;
    case (size)
      AXSIZE_1: mask = 64'h0000_0000_0000_00ff;
      AXSIZE_2: mask = 64'h0000_0000_0000_ffff;
      AXSIZE_4: mask = 64'h0000_0000_ffff_ffff;
      default:  mask = 64'hffff_ffff_ffff_ffff;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/axi_rd_mem.sv
// Word-addressed storage for the AXI read slave: synchronous preload write, asynchronous read.
module axi_rd_mem #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-only slave memory model with programmable latency.
// Define AXI_RD_SLAVE_BURST_EN to honour ARLEN; otherwise every request returns a single beat.
module axi_rd_slave
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       MEM_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int unsigned       RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StBeat} state_e;

  state_e            state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   id_q, rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q, burst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [3:0]        lat_q;

  logic [ADDR_W-1:0] beat_addr, beat_word, init_word;
  logic [DATA_W-1:0] mem_rdata, beat_data;
  logic [1:0]        beat_resp;
  logic              beat_last, dec_err, slv_err, init_ok;

`ifdef AXI_RD_SLAVE_BURST_EN
  logic [7:0] len_q, cnt_q, beat_cnt;

  // In BEAT the next beat is computed ahead so it can be presented right after a handshake.
  always_comb begin
    beat_addr = addr_q;
    beat_cnt  = 8'd0;
    if (state_q == StBeat) begin
      beat_addr = addr_q + (ADDR_W'(1) << size_q);
      beat_cnt  = cnt_q + 8'd1;
    end
  end

  assign beat_last = (beat_cnt == len_q);
`else
  logic unused_arlen;
  assign unused_arlen = ^ARLEN;
  assign beat_addr    = addr_q;
  assign beat_last    = 1'b1;
`endif

  assign beat_word = (beat_addr - BASE_ADDR) >> 3;
  assign dec_err   = (beat_addr < BASE_ADDR) || (beat_word >= ADDR_W'(MEM_WORDS));
  assign slv_err   = (burst_q != BURST_INCR) || (size_q > AXSIZE_8);

  always_comb begin
    beat_resp = RESP_OKAY;
    beat_data = '0;
    if (dec_err) begin
      beat_resp = RESP_DECERR;
    end else if (slv_err) begin
      beat_resp = RESP_SLVERR;
    end else begin
      beat_data = (mem_rdata >> {beat_addr[2:0], 3'b000}) & DATA_W'(lane_mask(size_q));
    end
  end

  assign init_word = (init_addr - BASE_ADDR) >> 3;
  assign init_ok   = init_we && (init_addr >= BASE_ADDR) && (init_word < ADDR_W'(MEM_WORDS));

  axi_rd_mem #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (init_ok),
    .waddr (init_word[IDX_W-1:0]),
    .wdata (init_wdata),
    .raddr (beat_word[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      lat_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ARVALID && arready_q) begin
            id_q      <= ARID;
            addr_q    <= ARADDR;
            size_q    <= ARSIZE;
            burst_q   <= ARBURST;
`ifdef AXI_RD_SLAVE_BURST_EN
            len_q     <= ARLEN;
`endif
            arready_q <= 1'b0;
            lat_q     <= 4'(RD_LATENCY - 1);
            state_q   <= StWait;
          end else begin
            arready_q <= 1'b1;
          end
        end
        StWait: begin
          if (lat_q == 4'd0) begin
            rvalid_q <= 1'b1;
            rid_q    <= id_q;
            rdata_q  <= beat_data;
            rresp_q  <= beat_resp;
            rlast_q  <= beat_last;
`ifdef AXI_RD_SLAVE_BURST_EN
            cnt_q    <= 8'd0;
`endif
            state_q  <= StBeat;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        StBeat: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= StIdle;
            end
`ifdef AXI_RD_SLAVE_BURST_EN
            else begin
              addr_q  <= beat_addr;
              cnt_q   <= beat_cnt;
              rdata_q <= beat_data;
              rresp_q <= beat_resp;
              rlast_q <= beat_last;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed scoreboard bench for axi_rd_slave; follows AXI_RD_SLAVE_BURST_EN like the RTL.
module tb_axi_rd_slave;

  localparam int unsigned   RD_LATENCY = 2;
  localparam logic [63:0]   BASE       = 64'h8000_0000;
  localparam int unsigned   WORDS      = 1024;
`ifdef AXI_RD_SLAVE_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        init_we;
  logic [63:0] init_addr, init_wdata;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] model [WORDS];
  int          checks = 0;
  int          errors = 0;

  axi_rd_slave #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ARID       (ARID),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .ARSIZE     (ARSIZE),
    .ARBURST    (ARBURST),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RID        (RID),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .RLAST      (RLAST),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_write(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    init_we    = 1'b1;
    init_addr  = addr;
    init_wdata = data;
    @(negedge clk);
    init_we = 1'b0;
    if (addr >= BASE && addr < BASE + 64'(WORDS * 8)) model[(addr - BASE) / 8] = data;
  endtask

  task automatic expect_beat(input logic [63:0] addr, input logic [2:0] size,
                             input logic [1:0] burst, output logic [63:0] d,
                             output logic [1:0] r);
    logic [63:0] w;
    d = 64'd0;
    if (addr < BASE || addr >= BASE + 64'(WORDS * 8)) begin
      r = 2'b11;
    end else if (burst != 2'b01 || size > 3'd3) begin
      r = 2'b10;
    end else begin
      r = 2'b00;
      w = model[(addr - BASE) / 8] >> (8 * int'(addr[2:0]));
      case (size)
        3'd0: d = {56'd0, w[7:0]};
        3'd1: d = {48'd0, w[15:0]};
        3'd2: d = {32'd0, w[31:0]};
        default: d = w;
      endcase
    end
  endtask

  task automatic check_beat_outputs(input beat_t e, input string tag);
    check({tag, "_rid"},   64'(RID),     64'(e.id));
    check({tag, "_rdata"}, RDATA,        e.data);
    check({tag, "_rresp"}, 64'(RRESP),   64'(e.resp));
    check({tag, "_rlast"}, 64'(RLAST),   64'(e.last));
    check({tag, "_arrdy"}, 64'(ARREADY), 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    int          n, t, lat;
    beat_t       e;
    logic [63:0] d;
    logic [1:0]  r;
    n = BurstEn ? int'(len) + 1 : 1;
    for (int i = 0; i < n; i++) begin
      expect_beat(addr + (64'(i) << size), size, burst, d, r);
      e.id = id; e.data = d; e.resp = r; e.last = (i == n - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ar_handshake", 64'(t < 20), 64'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    lat = 0;
    while (!RVALID && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(RD_LATENCY));
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        t = 0;
        while (!RVALID && t < 40) begin
          @(negedge clk);
          t++;
        end
        check("beat_gap", 64'(t), 64'd0);
      end
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_beat_outputs(e, "beat");
        if (b == stall_beat) begin
          RREADY = 1'b0;
          repeat (stall_cycles) begin
            @(negedge clk);
            check("hold_rvalid", 64'(RVALID), 64'd1);
            check_beat_outputs(e, "hold");
          end
          RREADY = 1'b1;
        end
      end
      @(negedge clk);
    end
    check("rvalid_drop", 64'(RVALID), 64'd0);
    check("arready_low", 64'(ARREADY), 64'd0);
    @(negedge clk);
    check("arready_back", 64'(ARREADY), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, 64'(ARREADY), 64'd0);
    check({tag, "_rvalid"},  64'(RVALID),  64'd0);
    check({tag, "_rlast"},   64'(RLAST),   64'd0);
    check({tag, "_rid"},     64'(RID),     64'd0);
    check({tag, "_rdata"},   RDATA,        64'd0);
    check({tag, "_rresp"},   64'(RRESP),   64'd0);
  endtask

  initial begin
    int t;
    rstn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
    ARBURST = 2'b01; RREADY = 1'b1; init_we = 1'b0; init_addr = '0; init_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_arready", 64'(ARREADY), 64'd1);

    init_write(BASE + 64'h00,   64'h1122_3344_5566_7788);
    init_write(BASE + 64'h08,   64'h99aa_bbcc_ddee_ff00);
    init_write(BASE + 64'h10,   64'h0123_4567_89ab_cdef);
    init_write(BASE + 64'h18,   64'hfedc_ba98_7654_3210);
    init_write(BASE + 64'h1ff8, 64'h5a5a_a5a5_3c3c_c3c3);
    // Out-of-range preloads must not alias onto word 0 or the last word.
    init_write(BASE + 64'(WORDS * 8), 64'hdead_beef_dead_beef);
    init_write(64'h7fff_fff8,         64'hbad0_bad0_bad0_bad0);

    do_read(4'd0, 64'h8000_0004, 8'd0, 3'd2, 2'b01, -1, 0);
    do_read(4'd1, 64'h8000_0000, 8'd3, 3'd3, 2'b01, -1, 0);
    do_read(4'd1, 64'h8000_0000, 8'd3, 3'd3, 2'b01, BurstEn ? 1 : 0, 3);
    do_read(4'd5, 64'h7fff_fff8, 8'd0, 3'd3, 2'b01, -1, 0);
    do_read(4'd6, 64'h8000_0008, 8'd0, 3'd3, 2'b10, -1, 0);
    do_read(4'd7, 64'h8000_0003, 8'd0, 3'd0, 2'b01, -1, 0);
    do_read(4'd8, 64'h8000_0006, 8'd1, 3'd1, 2'b01, -1, 0);
    do_read(4'd9, 64'h8000_1ff8, 8'd1, 3'd3, 2'b01, -1, 0);
    do_read(4'd10, 64'h8000_0000, 8'd7, 3'd0, 2'b01, -1, 0);

    // Reset in the middle of a burst (on beat 2 when bursts are enabled).
    @(negedge clk);
    ARID = 4'd2; ARADDR = 64'h8000_0000; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01;
    ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst_first_beat", 64'(RVALID), 64'd1);
`ifdef AXI_RD_SLAVE_BURST_EN
    @(negedge clk);
    check("mid_rst_second_beat", 64'(RVALID), 64'd1);
`endif
    RREADY = 1'b0;
    rstn   = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rstn   = 1'b1;
    RREADY = 1'b1;
    @(negedge clk);
    check("mid_rst_arready", 64'(ARREADY), 64'd1);
    check("mid_rst_rvalid", 64'(RVALID), 64'd0);
    do_read(4'd3, 64'h8000_0008, 8'd0, 3'd3, 2'b01, -1, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_slave.md
# axi_rd_slave

AXI4 read-only slave memory model that sits directly downstream of the pipeline's AXI read master (instruction fetch and load port). It accepts one AR request at a time and returns R beats after a programmable latency. It supports INCR bursts and narrow transfers, and reports out-of-range or unsupported accesses through RRESP. Contents are preloaded through a simple init write port.

## Interface
- ADDR_W, 64, AR/init address width
- DATA_W, 64, R data width (8-byte words)
- ID_W, 4, ARID/RID width
- MEM_WORDS, 1024, memory depth in DATA_W words
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- RD_LATENCY, 2, cycles from AR handshake to first RVALID; legal range 1–15
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- ARID  in  ID_W  request ID
- ARADDR  in  ADDR_W  byte address
- ARLEN  in  8  beats minus one
- ARSIZE  in  3  log2 bytes per beat; 0–3 legal
- ARBURST  in  2  burst type
- ARVALID  in  1  request valid
- ARREADY  out  1  request accepted, registered
- RID  out  ID_W  echoes captured ARID
- RDATA  out  DATA_W  read data, right-justified
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- RLAST  out  1  final beat
- RVALID  out  1  beat valid
- RREADY  in  1  beat accepted
- init_we  in  1  preload write enable; legal only when the block is in IDLE
- init_addr  in  ADDR_W  preload byte address, 8-byte aligned
- init_wdata  in  DATA_W  preload word

## Operation
- FSM states: IDLE, WAIT, BEAT.
- IDLE:
  - ARREADY=1 from the cycle after IDLE is entered.
  - On ARVALID&&ARREADY: capture ID, address, length, size and burst; clear ARREADY; load the latency counter with RD_LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0: compute the current beat, assert RVALID, go to BEAT.
- BEAT:
  - RID, RDATA, RRESP and RLAST are held stable while RVALID && !RREADY.
  - On RVALID&&RREADY with a non-last beat: address += 1<<size, beat counter +1, next beat presented the following cycle (no added latency between beats).
  - On RVALID&&RREADY with the last beat: RVALID=0, go to IDLE.
- Beat data:
  - word = (addr-BASE_ADDR)>>3.
  - RDATA = mem[word] >> (addr[2:0]*8), with bits above 8<<size zeroed.
  - Example: size 2 at offset 4 returns the upper 32 bits in RDATA[31:0].
- RLAST = (beat counter == captured length).
- RRESP:
  - DECERR with RDATA=0 when addr<BASE_ADDR or word>=MEM_WORDS.
  - SLVERR with RDATA=0 when ARBURST!=INCR or ARSIZE>3.
  - Otherwise OKAY.
  - Evaluated per beat, so a burst crossing the end of memory returns OKAY then DECERR beats.
- Reset, including mid-burst:
  - ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0.
  - FSM returns to IDLE and the in-flight burst is abandoned.
  - Memory contents are retained.
- init_we: writes mem[(init_addr-BASE_ADDR)>>3]. Out-of-range writes are dropped.

## Timing
- AR accepted at edge N: first RVALID high after edge N+RD_LATENCY.
- With RREADY held high, an L-beat burst occupies RD_LATENCY+L cycles.
- ARREADY returns high one cycle after the last beat handshake.
- Minimum request-to-request spacing: RD_LATENCY+L+1 cycles.
- ARREADY is never high while RVALID is high.

## Configuration
- AXI_RD_SLAVE_BURST_EN defined: ARLEN honoured, up to 256 beats.
- Undefined: captured length is forced to 0. Every request returns exactly one beat with RLAST=1, and ARLEN is ignored. The beat counter and address-increment logic are removed.

## Structure
- Shared package axi_pkg holds:
  - xRESP codes OKAY/EXOKAY/SLVERR/DECERR
  - AxBURST FIXED/INCR/WRAP
  - AxSIZE_1..AxSIZE_8 constants
  - these are shared with the AXI read master
- Sub-module axi_rd_mem: MEM_WORDS×DATA_W array with the init write port and an asynchronous read port. The FSM, counters and lane shifting stay in axi_rd_slave.

## Test plan
- Preload mem[0]=64'h1122_3344_5566_7788. AR addr 8000_0004, size 2, len 0, ID 0, RD_LATENCY 2 -> RVALID exactly 2 cycles after the handshake; RDATA=64'h0000_0000_1122_3344, RLAST=1, RRESP=OKAY, RID=0.
- AR addr 8000_0000, size 3, len 3, ID 1, RREADY held high (BURST_EN) -> 4 consecutive beats from mem[0..3], RLAST only on beat 4, RID=1 on every beat.
- Same burst with RREADY low for 3 cycles on beat 2 -> beat 2 held stable; no beat lost or duplicated.
- AR addr 7FFF_FFF8 -> DECERR, RDATA=0. AR with ARBURST=WRAP -> SLVERR.
- rstn low during beat 2 of a 4-beat burst -> next cycle all outputs 0 and FSM in IDLE. After release, ARREADY=1 and a new single read returns the preloaded data.
- BURST_EN undefined: AR len 7 -> single beat with RLAST=1.
